// File: rtl/first_one.sv
// Isolates the lowest set bit of vec_i as a one-hot vector; purely combinational.
// "fast" uses the two's-complement trick, "small" a ripple priority chain.
module first_one #(
  parameter int    WIDTH   = 8,
  parameter string VARIANT = "fast"
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [WIDTH-1:0] onehot_o
);

  if (VARIANT == "fast") begin : g_fast
    assign onehot_o = vec_i & (~vec_i + {{(WIDTH-1){1'b0}}, 1'b1});
  end else begin : g_small
    if (VARIANT != "small") begin : g_bad_variant
      $error("first_one: VARIANT must be \"small\" or \"fast\"");
    end

    logic seen;

    always_comb begin
      seen     = 1'b0;
      onehot_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
        onehot_o[i] = vec_i[i] & ~seen;
        seen        = seen | vec_i[i];
      end
    end
  end

endmodule

// File: rtl/onehot_to_binary.sv
// Combinational one-hot to binary index encoder; an all-zero input encodes to 0.
module onehot_to_binary #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         onehot_i,
  output logic [$clog2(WIDTH)-1:0] index_o
);

  localparam int INDEX_WIDTH = $clog2(WIDTH);

  always_comb begin
    index_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot_i[i]) index_o = index_o | INDEX_WIDTH'(i);
    end
  end

endmodule

// File: rtl/pending_request_scheduler.sv
// Sticky request accumulator that offers one pending bit at a time on a valid/ready grant port.
// All outputs registered; a set appears on grant_valid two cycles later, grants held while stalled.
module pending_request_scheduler #(
  parameter int    WIDTH             = 8,
  parameter string VARIANT           = "fixed",
  parameter string FIRST_ONE_VARIANT = "fast"
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         set_mask,
  output logic [WIDTH-1:0]         pending,
  output logic                     grant_valid,
  input  logic                     grant_ready,
  output logic [WIDTH-1:0]         grant_onehot,
  output logic [$clog2(WIDTH)-1:0] grant_index
);

  localparam int   INDEX_WIDTH = $clog2(WIDTH);
  localparam logic ST_IDLE     = 1'b0;
  localparam logic ST_OFFER    = 1'b1;

  logic                   state_q, state_d;
  logic [WIDTH-1:0]       pending_q, pending_d;
  logic [WIDTH-1:0]       onehot_q, onehot_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;

  logic                   xfer;
  logic [WIDTH-1:0]       rem;
  logic [WIDTH-1:0]       sel_onehot;
  logic [INDEX_WIDTH-1:0] sel_index;

  assign xfer = (state_q == ST_OFFER) && grant_ready && !flush;
  // rem excludes the accepted bit but not same-cycle sets, so a re-set bit waits a cycle.
  assign rem       = xfer ? (pending_q & ~onehot_q) : pending_q;
  assign pending_d = flush ? '0 : (rem | set_mask);

  if (VARIANT == "round_robin") begin : g_rr
    logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
    logic [INDEX_WIDTH-1:0] sel_ptr;
    logic [WIDTH-1:0]       upper, upper_oh, any_oh;

    // The bit just accepted becomes the new priority floor for the follow-on selection.
    assign sel_ptr = xfer ? index_q : ptr_q;
    assign ptr_d   = flush ? INDEX_WIDTH'(WIDTH - 1) : (xfer ? index_q : ptr_q);

    always_comb begin
      upper = '0;
      for (int i = 0; i < WIDTH; i++) begin
        upper[i] = rem[i] && (i > int'(sel_ptr));
      end
    end

    first_one #(.WIDTH(WIDTH), .VARIANT(FIRST_ONE_VARIANT)) u_first_upper (
      .vec_i    (upper),
      .onehot_o (upper_oh)
    );

    first_one #(.WIDTH(WIDTH), .VARIANT(FIRST_ONE_VARIANT)) u_first_any (
      .vec_i    (rem),
      .onehot_o (any_oh)
    );

    assign sel_onehot = (|upper) ? upper_oh : any_oh;

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) ptr_q <= INDEX_WIDTH'(WIDTH - 1);
      else         ptr_q <= ptr_d;
    end
  end else begin : g_fixed
    if (VARIANT != "fixed") begin : g_bad_variant
      $error("pending_request_scheduler: VARIANT must be \"fixed\" or \"round_robin\"");
    end

    first_one #(.WIDTH(WIDTH), .VARIANT(FIRST_ONE_VARIANT)) u_first (
      .vec_i    (rem),
      .onehot_o (sel_onehot)
    );
  end

  onehot_to_binary #(.WIDTH(WIDTH)) u_encode (
    .onehot_i (sel_onehot),
    .index_o  (sel_index)
  );

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    index_d  = index_q;
    if (flush) begin
      state_d  = ST_IDLE;
      onehot_d = '0;
      index_d  = '0;
    end else if (state_q == ST_IDLE || xfer) begin
      if (|rem) begin
        state_d  = ST_OFFER;
        onehot_d = sel_onehot;
        index_d  = sel_index;
      end else begin
        state_d  = ST_IDLE;
        onehot_d = '0;
        index_d  = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      onehot_q  <= '0;
      index_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      onehot_q  <= onehot_d;
      index_q   <= index_d;
    end
  end

  assign pending      = pending_q;
  assign grant_valid  = (state_q == ST_OFFER);
  assign grant_onehot = onehot_q;
  assign grant_index  = index_q;

endmodule

// File: tb/tb_pending_request_scheduler.sv
// Drives a fixed-priority and a round-robin scheduler with identical stimulus;
// expected grants are queued per instance and checked by a negedge monitor.
module tb_pending_request_scheduler;

  logic       clock;
  logic       resetn;
  logic       flush;
  logic [7:0] set_mask;
  logic       grant_ready;

  logic [7:0] fix_pending, fix_onehot, rr_pending, rr_onehot;
  logic       fix_valid, rr_valid;
  logic [2:0] fix_index, rr_index;

  typedef struct packed {
    logic [7:0] oh;
    logic [2:0] idx;
  } exp_t;

  exp_t q_fix[$];
  exp_t q_rr[$];
  int   errors;
  int   checks;
  int   xfer_fix;

  pending_request_scheduler #(.WIDTH(8), .VARIANT("fixed"), .FIRST_ONE_VARIANT("fast")) u_fix (
    .clock        (clock),
    .resetn       (resetn),
    .flush        (flush),
    .set_mask     (set_mask),
    .pending      (fix_pending),
    .grant_valid  (fix_valid),
    .grant_ready  (grant_ready),
    .grant_onehot (fix_onehot),
    .grant_index  (fix_index)
  );

  pending_request_scheduler #(.WIDTH(8), .VARIANT("round_robin"), .FIRST_ONE_VARIANT("small")) u_rr (
    .clock        (clock),
    .resetn       (resetn),
    .flush        (flush),
    .set_mask     (set_mask),
    .pending      (rr_pending),
    .grant_valid  (rr_valid),
    .grant_ready  (grant_ready),
    .grant_onehot (rr_onehot),
    .grant_index  (rr_index)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic [7:0] pend, input logic vld,
                           input logic [7:0] oh, input logic [2:0] idx);
    chk({name, " fix pending"}, 32'(fix_pending), 32'(pend));
    chk({name, " fix valid"},   32'(fix_valid),   32'(vld));
    chk({name, " fix onehot"},  32'(fix_onehot),  32'(oh));
    chk({name, " fix index"},   32'(fix_index),   32'(idx));
    chk({name, " rr pending"},  32'(rr_pending),  32'(pend));
    chk({name, " rr valid"},    32'(rr_valid),    32'(vld));
    chk({name, " rr onehot"},   32'(rr_onehot),   32'(oh));
    chk({name, " rr index"},    32'(rr_index),    32'(idx));
  endtask

  task automatic push(input bit to_fix, input bit to_rr, input logic [7:0] oh, input logic [2:0] idx);
    exp_t e;
    e.oh  = oh;
    e.idx = idx;
    if (to_fix) q_fix.push_back(e);
    if (to_rr)  q_rr.push_back(e);
  endtask

  task automatic mon_cmp(input bit is_rr, input logic [7:0] oh, input logic [2:0] idx);
    exp_t  e;
    bit    have;
    string who;
    who  = is_rr ? "rr" : "fix";
    have = 1'b0;
    e    = '0;
    if (is_rr) begin
      if (q_rr.size() != 0) begin have = 1'b1; e = q_rr.pop_front(); end
    end else begin
      if (q_fix.size() != 0) begin have = 1'b1; e = q_fix.pop_front(); end
    end
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s unexpected grant: got onehot=%b index=%0d, required no transfer", who, oh, idx);
    end else if (oh !== e.oh || idx !== e.idx) begin
      errors++;
      $display("FAIL %s grant: got onehot=%b index=%0d, required onehot=%b index=%0d",
               who, oh, idx, e.oh, e.idx);
    end
  endtask

  // A transfer is decided at the next rising edge, so inputs seen here are the ones it will use.
  always @(negedge clock) begin
    if (resetn && grant_ready && !flush) begin
      if (fix_valid) begin
        xfer_fix++;
        mon_cmp(1'b0, fix_onehot, fix_index);
      end
      if (rr_valid) mon_cmp(1'b1, rr_onehot, rr_index);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_xfers(input int n);
    int target;
    int budget;
    target = xfer_fix + n;
    budget = 64;
    while (xfer_fix < target && budget > 0) begin
      @(negedge clock);
      #1;
      budget--;
    end
    if (xfer_fix < target) begin
      checks++;
      errors++;
      $display("FAIL wait_xfers timeout: got %0d transfers, required %0d", xfer_fix, target);
    end
    step();
  endtask

  task automatic do_reset();
    grant_ready = 1'b0;
    flush       = 1'b0;
    set_mask    = '0;
    resetn      = 1'b0;
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic chk_drained(input string name);
    chk({name, " fix queue left"}, 32'(q_fix.size()), 32'd0);
    chk({name, " rr queue left"},  32'(q_rr.size()),  32'd0);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    xfer_fix    = 0;
    resetn      = 1'b0;
    flush       = 1'b0;
    set_mask    = '0;
    grant_ready = 1'b0;

    // Reset and idle
    repeat (3) step();
    chk_state("in_reset", 8'h00, 1'b0, 8'h00, 3'd0);
    resetn = 1'b1;
    repeat (3) step();
    chk_state("idle", 8'h00, 1'b0, 8'h00, 3'd0);

    // Fixed drain: back-to-back 2, 5, 7 for both policies
    do_reset();
    push(1, 1, 8'b0000_0100, 3'd2);
    push(1, 1, 8'b0010_0000, 3'd5);
    push(1, 1, 8'b1000_0000, 3'd7);
    grant_ready = 1'b1;
    set_mask    = 8'b1010_0100;
    step();
    set_mask = '0;
    chk_state("drain_latency", 8'b1010_0100, 1'b0, 8'h00, 3'd0);
    wait_xfers(3);
    grant_ready = 1'b0;
    step();
    chk_state("drain_end", 8'h00, 1'b0, 8'h00, 3'd0);
    chk_drained("drain");

    // Backpressure: bit 3 held while bit 0 arrives
    do_reset();
    push(1, 1, 8'b0000_1000, 3'd3);
    push(1, 1, 8'b0000_0001, 3'd0);
    set_mask = 8'b0000_1000;
    step();
    set_mask = '0;
    step();
    for (int i = 0; i < 5; i++) begin
      set_mask = (i == 1) ? 8'b0000_0001 : 8'h00;
      chk("stall fix onehot", 32'(fix_onehot), 32'h08);
      chk("stall rr index",   32'(rr_index),   32'd3);
      step();
    end
    set_mask = '0;
    chk_state("stall_end", 8'b0000_1001, 1'b1, 8'b0000_1000, 3'd3);
    grant_ready = 1'b1;
    wait_xfers(1);
    chk_state("after_stall", 8'b0000_0001, 1'b1, 8'b0000_0001, 3'd0);
    wait_xfers(1);
    grant_ready = 1'b0;
    chk_state("stall_drained", 8'h00, 1'b0, 8'h00, 3'd0);
    chk_drained("backpressure");

    // Fairness with a constant request mask
    do_reset();
    for (int i = 0; i < 12; i++) begin
      push(1, 0, (i % 2 == 0) ? 8'b0000_0001 : 8'b0000_0010, 3'(i % 2));
      push(0, 1, 8'(1 << (i % 3)), 3'(i % 3));
    end
    grant_ready = 1'b1;
    set_mask    = 8'b0000_0111;
    wait_xfers(12);
    grant_ready = 1'b0;
    set_mask    = '0;
    chk_drained("fairness");

    // Set-versus-clear collision on bit 4
    do_reset();
    push(1, 1, 8'b0001_0000, 3'd4);
    push(1, 1, 8'b0001_0000, 3'd4);
    set_mask = 8'b0001_0000;
    step();
    set_mask = '0;
    step();
    chk_state("collide_offer", 8'b0001_0000, 1'b1, 8'b0001_0000, 3'd4);
    grant_ready = 1'b1;
    set_mask    = 8'b0001_0000;
    step();
    grant_ready = 1'b0;
    set_mask    = '0;
    chk_state("collide_idle", 8'b0001_0000, 1'b0, 8'h00, 3'd0);
    step();
    chk_state("collide_regrant", 8'b0001_0000, 1'b1, 8'b0001_0000, 3'd4);
    grant_ready = 1'b1;
    step();
    grant_ready = 1'b0;
    chk_state("collide_end", 8'h00, 1'b0, 8'h00, 3'd0);
    chk_drained("collision");

    // Flush mid-offer after the round-robin pointer has moved to 3
    do_reset();
    push(1, 1, 8'b0000_1000, 3'd3);
    set_mask = 8'b1111_1000;
    step();
    set_mask = '0;
    step();
    grant_ready = 1'b1;
    wait_xfers(1);
    grant_ready = 1'b0;
    chk_state("pre_flush", 8'b1111_0000, 1'b1, 8'b0001_0000, 3'd4);
    flush       = 1'b1;
    grant_ready = 1'b1;
    set_mask    = 8'b0000_0001;
    step();
    flush       = 1'b0;
    grant_ready = 1'b0;
    set_mask    = '0;
    chk_state("post_flush", 8'h00, 1'b0, 8'h00, 3'd0);
    chk_drained("flush");
    for (int i = 0; i < 8; i++) push(1, 1, 8'(1 << i), 3'(i));
    set_mask    = 8'hFF;
    grant_ready = 1'b1;
    step();
    set_mask = '0;
    wait_xfers(8);
    grant_ready = 1'b0;
    step();
    chk_state("refill_end", 8'h00, 1'b0, 8'h00, 3'd0);
    chk_drained("refill");

    // Asynchronous reset during an offer
    do_reset();
    set_mask = 8'b0100_0000;
    step();
    set_mask = '0;
    step();
    chk_state("pre_async", 8'b0100_0000, 1'b1, 8'b0100_0000, 3'd6);
    #2;
    resetn = 1'b0;
    #1;
    chk_state("async_reset", 8'h00, 1'b0, 8'h00, 3'd0);
    step();
    resetn = 1'b1;
    step();
    chk_drained("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
